// File: rtl/board_state_if.sv
// Link handshake bundle: remote moves in (rx) and local moves out (tx).
interface board_state_if;
  localparam int unsigned PKT_W = 12;

  logic             rx_valid;
  logic [PKT_W-1:0] rx_packet;
  logic             rx_ready;
  logic             tx_valid;
  logic [PKT_W-1:0] tx_packet;
  logic             tx_ready;

  // Board side: consumes rx moves, offers tx moves.
  modport slave (
    input  rx_valid, rx_packet, tx_ready,
    output rx_ready, tx_valid, tx_packet
  );

  // Link side: offers rx moves, consumes tx moves.
  modport master (
    output rx_valid, rx_packet, tx_ready,
    input  rx_ready, tx_valid, tx_packet
  );
endinterface

// File: rtl/board_state.sv
// Authoritative chess board store: applies local and remote moves, forwards
// local moves to the link, tracks the side to move and detects king capture.
module board_state (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   player,
  input  logic                   new_game,
  input  logic                   moved,
  input  logic [11:0]            move_packet,
  board_state_if.slave           link,
  output logic [7:0][7:0][3:0]   stable_board,
  output logic                   curr_player,
  output logic                   game_over,
  output logic                   winner
);

  localparam int unsigned PC_W  = 4;
  localparam int unsigned CO_W  = 3;
  localparam int unsigned PKT_W = 12;

  localparam logic [PC_W-1:0] EMPTY    = 4'd15;
  localparam logic [PC_W-1:0] PAWN_1   = 4'd0;
  localparam logic [PC_W-1:0] QUEEN_1  = 4'd4;
  localparam logic [PC_W-1:0] KING_1   = 4'd5;
  localparam logic [PC_W-1:0] PAWN_0   = 4'd6;
  localparam logic [PC_W-1:0] QUEEN_0  = 4'd10;
  localparam logic [PC_W-1:0] KING_0   = 4'd11;

  typedef enum logic [1:0] {IDLE, SEND, OVER} state_t;

  state_t                       state_q;
  logic [7:0][7:0][PC_W-1:0]    board_q;
  logic                         curr_player_q;
  logic                         game_over_q;
  logic                         winner_q;
  logic                         tx_valid_q;
  logic [PKT_W-1:0]             tx_packet_q;

  logic                         local_go_c;
  logic                         rx_ready_c;
  logic [PKT_W-1:0]             mv_c;
  logic [CO_W-1:0]              ox_c, oy_c, nx_c, ny_c;
  logic [PC_W-1:0]              src_c, dst_old_c, dst_new_c;
  logic                         null_c;
  logic                         king_hit_c;

  // Opening position; back rows listed x=7 down to x=0.
  function automatic logic [7:0][7:0][PC_W-1:0] start_pos();
    logic [7:0][7:0][PC_W-1:0] b;
    logic [7:0][PC_W-1:0]      back;
    back = {4'd3, 4'd1, 4'd2, 4'd5, 4'd4, 4'd2, 4'd1, 4'd3};
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        b[y][x] = EMPTY;
      end
    end
    for (int x = 0; x < 8; x++) begin
      b[0][x] = back[x];
      b[1][x] = PAWN_1;
      b[6][x] = PAWN_0;
      b[7][x] = PC_W'(back[x] + 4'd6);
    end
    return b;
  endfunction

  // Move selection and decode; local and remote acceptance are mutually
  // exclusive because they require opposite turn states.
  always_comb begin
    local_go_c = (state_q == IDLE) && !new_game && moved && (curr_player_q == player);
    rx_ready_c = (state_q == IDLE) && !new_game && link.rx_valid && (curr_player_q != player);
    mv_c       = local_go_c ? move_packet : link.rx_packet;
    ox_c       = mv_c[11:9];
    oy_c       = mv_c[8:6];
    nx_c       = mv_c[5:3];
    ny_c       = mv_c[2:0];
    src_c      = board_q[oy_c][ox_c];
    dst_old_c  = board_q[ny_c][nx_c];
    null_c     = (mv_c[11:6] == mv_c[5:0]) || (src_c == EMPTY);
    king_hit_c = (dst_old_c == KING_1) || (dst_old_c == KING_0);
    dst_new_c  = src_c;
    if ((src_c == PAWN_1) && (ny_c == 3'd7)) dst_new_c = QUEEN_1;
    if ((src_c == PAWN_0) && (ny_c == 3'd0)) dst_new_c = QUEEN_0;
  end

  // Game FSM, board array and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      board_q       <= start_pos();
      curr_player_q <= 1'b1;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_packet_q   <= '0;
    end else if (new_game) begin
      state_q       <= IDLE;
      board_q       <= start_pos();
      curr_player_q <= 1'b1;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_packet_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((local_go_c || rx_ready_c) && !null_c) begin
            board_q[ny_c][nx_c] <= dst_new_c;
            board_q[oy_c][ox_c] <= EMPTY;
            curr_player_q       <= ~curr_player_q;
            if (king_hit_c) begin
              game_over_q <= 1'b1;
              winner_q    <= local_go_c ? player : ~player;
            end
            if (local_go_c) begin
              tx_packet_q <= move_packet;
              tx_valid_q  <= 1'b1;
              state_q     <= SEND;
            end else if (king_hit_c) begin
              state_q     <= OVER;
            end
          end
        end
        SEND: begin
          if (link.tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= game_over_q ? OVER : IDLE;
          end
        end
        OVER: begin
          state_q <= OVER;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign link.rx_ready  = rx_ready_c;
  assign link.tx_valid  = tx_valid_q;
  assign link.tx_packet = tx_packet_q;
  assign stable_board   = board_q;
  assign curr_player    = curr_player_q;
  assign game_over      = game_over_q;
  assign winner         = winner_q;

endmodule

// File: tb/tb_board_state.sv
// Directed bench for board_state: hand-computed expectations per step.
module tb_board_state;

  logic                 clk;
  logic                 reset_n;
  logic                 player;
  logic                 new_game;
  logic                 moved;
  logic [11:0]          move_packet;
  logic [7:0][7:0][3:0] board;
  logic                 curr_player;
  logic                 game_over;
  logic                 winner;

  int vectors = 0;
  int errs    = 0;

  board_state_if link ();

  board_state dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .player       (player),
    .new_game     (new_game),
    .moved        (moved),
    .move_packet  (move_packet),
    .link         (link.slave),
    .stable_board (board),
    .curr_player  (curr_player),
    .game_over    (game_over),
    .winner       (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, returning at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n        = 1'b0;
    player         = 1'b1;
    new_game       = 1'b0;
    moved          = 1'b0;
    move_packet    = '0;
    link.rx_valid  = 1'b0;
    link.rx_packet = '0;
    link.tx_ready  = 1'b0;
    #12;
    chk("rst_king",   32'(board[0][4]), 32'd5);
    chk("rst_queen0", 32'(board[7][3]), 32'd10);
    chk("rst_empty",  32'(board[3][3]), 32'd15);
    chk("rst_curr",   32'(curr_player), 32'd1);
    chk("rst_txv",    32'(link.tx_valid), 32'd0);
    chk("rst_txp",    32'(link.tx_packet), 32'd0);
    chk("rst_over",   32'(game_over), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Local pawn x1,y1 -> x1,y3 with a stalled link.
    moved = 1'b1; move_packet = 12'h24B;
    tick();
    moved = 1'b0;
    chk("mv_src",  32'(board[1][1]), 32'd15);
    chk("mv_dst",  32'(board[3][1]), 32'd0);
    chk("mv_curr", 32'(curr_player), 32'd0);
    chk("mv_txv",  32'(link.tx_valid), 32'd1);
    chk("mv_txp",  32'(link.tx_packet), 32'h24B);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_txv", 32'(link.tx_valid), 32'd1);
      chk("stall_txp", 32'(link.tx_packet), 32'h24B);
    end
    link.tx_ready = 1'b1;
    tick();
    link.tx_ready = 1'b0;
    chk("tx_done", 32'(link.tx_valid), 32'd0);

    // Remote pawn x4,y6 -> x4,y4.
    link.rx_valid = 1'b1; link.rx_packet = 12'h9A4;
    #1;
    chk("rx_ready", 32'(link.rx_ready), 32'd1);
    tick();
    link.rx_valid = 1'b0;
    chk("rx_dst",  32'(board[4][4]), 32'd6);
    chk("rx_src",  32'(board[6][4]), 32'd15);
    chk("rx_curr", 32'(curr_player), 32'd1);
    chk("rx_notx", 32'(link.tx_valid), 32'd0);
    // Out-of-turn remote move is refused.
    link.rx_valid = 1'b1; link.rx_packet = 12'h79C;
    #1;
    chk("rx_refuse", 32'(link.rx_ready), 32'd0);
    tick();
    link.rx_valid = 1'b0;
    chk("rx_ref_brd",  32'(board[4][3]), 32'd15);
    chk("rx_ref_curr", 32'(curr_player), 32'd1);

    // Pawn x0,y1 -> x0,y6 with link ready: one-cycle tx.
    link.tx_ready = 1'b1;
    moved = 1'b1; move_packet = 12'h046;
    tick();
    moved = 1'b0;
    chk("min_txv1", 32'(link.tx_valid), 32'd1);
    chk("pre_promo", 32'(board[6][0]), 32'd0);
    tick();
    chk("min_txv0", 32'(link.tx_valid), 32'd0);
    // Remote filler x7,y6 -> x7,y5.
    link.rx_valid = 1'b1; link.rx_packet = 12'hFBD;
    tick();
    link.rx_valid = 1'b0;
    chk("fill_curr", 32'(curr_player), 32'd1);
    // Pawn x0,y6 -> x0,y7 promotes to queen.
    moved = 1'b1; move_packet = 12'h187;
    tick();
    moved = 1'b0;
    chk("promo",     32'(board[7][0]), 32'd4);
    chk("promo_src", 32'(board[6][0]), 32'd15);
    tick();
    link.tx_ready = 1'b0;
    // Remote filler x7,y5 -> x7,y4.
    link.rx_valid = 1'b1; link.rx_packet = 12'hF7C;
    tick();
    link.rx_valid = 1'b0;
    chk("fill2_curr", 32'(curr_player), 32'd1);

    // Queen x0,y7 -> x4,y7 captures the side-0 king.
    moved = 1'b1; move_packet = 12'h1E7;
    tick();
    moved = 1'b0;
    chk("kc_dst",    32'(board[7][4]), 32'd4);
    chk("kc_over",   32'(game_over), 32'd1);
    chk("kc_winner", 32'(winner), 32'd1);
    chk("kc_txv",    32'(link.tx_valid), 32'd1);
    tick();
    chk("kc_hold", 32'(link.tx_valid), 32'd1);
    link.tx_ready = 1'b1;
    tick();
    link.tx_ready = 1'b0;
    chk("kc_txdone", 32'(link.tx_valid), 32'd0);
    // Frozen board in OVER.
    link.rx_valid = 1'b1; link.rx_packet = 12'h79C;
    #1;
    chk("over_rxr", 32'(link.rx_ready), 32'd0);
    tick();
    link.rx_valid = 1'b0;
    chk("over_rx_brd", 32'(board[6][3]), 32'd6);
    moved = 1'b1; move_packet = 12'h212;
    tick();
    moved = 1'b0;
    chk("over_mv_brd", 32'(board[0][1]), 32'd1);
    chk("over_mv_txv", 32'(link.tx_valid), 32'd0);
    chk("over_still",  32'(game_over), 32'd1);

    // New game restores the opening.
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("ng_king",   32'(board[7][4]), 32'd11);
    chk("ng_rook",   32'(board[7][0]), 32'd9);
    chk("ng_over",   32'(game_over), 32'd0);
    chk("ng_winner", 32'(winner), 32'd0);
    chk("ng_curr",   32'(curr_player), 32'd1);

    // New game aborts a stalled SEND.
    moved = 1'b1; move_packet = 12'h24B;
    tick();
    moved = 1'b0;
    chk("ab_txv1", 32'(link.tx_valid), 32'd1);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("ab_txv0", 32'(link.tx_valid), 32'd0);
    chk("ab_txp",  32'(link.tx_packet), 32'd0);
    chk("ab_src",  32'(board[1][1]), 32'd0);
    chk("ab_dst",  32'(board[3][1]), 32'd15);
    chk("ab_curr", 32'(curr_player), 32'd1);

    // Null moves: old==new, then empty source.
    moved = 1'b1; move_packet = 12'h249;
    tick();
    moved = 1'b0;
    chk("null_brd",  32'(board[1][1]), 32'd0);
    chk("null_curr", 32'(curr_player), 32'd1);
    chk("null_txv",  32'(link.tx_valid), 32'd0);
    moved = 1'b1; move_packet = 12'h6DC;
    tick();
    moved = 1'b0;
    chk("nullsrc_brd",  32'(board[4][3]), 32'd15);
    chk("nullsrc_curr", 32'(curr_player), 32'd1);
    chk("nullsrc_txv",  32'(link.tx_valid), 32'd0);

    // Asynchronous reset mid-SEND.
    moved = 1'b1; move_packet = 12'h24B;
    tick();
    moved = 1'b0;
    chk("ar_txv1", 32'(link.tx_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_txv0", 32'(link.tx_valid), 32'd0);
    chk("ar_brd",  32'(board[1][1]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
